// File: rtl/vma_unit.sv
// Virtual-memory-address register for the CADR datapath: VMA load/increment/spy
// paths, previous-VMA restart copy, and a single-outstanding memory request FSM.
module vma_unit #(
  parameter int ADDR_W   = 32,
  parameter int SPY_W    = 16,
  parameter int INC_STEP = 1,
  localparam int NCHUNK  = ADDR_W / SPY_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              state_alu,
  input  logic              state_write,
  input  logic              state_fetch,
  input  logic              vmaenb,
  input  logic [ADDR_W-1:0] vmas,
  input  logic              vma_inc,
  input  logic [SPY_W-1:0]  spy_in,
  input  logic [NCHUNK-1:0] ldvma,
  input  logic              srcvma,
  input  logic              mem_start,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] vma,
  output logic [ADDR_W-1:0] vma_prev,
  output logic              vmadrive,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_busy,
  output logic              vma_wait
);

  typedef enum logic {IDLE, REQ} mem_state_t;

  mem_state_t           state, state_next;
  logic [ADDR_W-1:0]    vma_spy;
  logic [ADDR_W-1:0]    vma_next;
  logic                 prev_load;
  logic                 addr_load;

  // Spy chunks overwrite only the strobed slices; every strobed slice gets spy_in.
  always_comb begin
    vma_spy = vma;
    for (int k = 0; k < NCHUNK; k++) begin
      if (ldvma[k]) vma_spy[k*SPY_W +: SPY_W] = spy_in;
    end
  end

  always_comb begin
    vma_next  = vma;
    prev_load = 1'b0;
    if (state_alu && vmaenb) begin
      vma_next  = vmas;
      prev_load = 1'b1;
    end else if (state_alu && vma_inc) begin
      vma_next  = vma + ADDR_W'(INC_STEP);
      prev_load = 1'b1;
    end else if (|ldvma) begin
      vma_next  = vma_spy;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vma      <= '0;
      vma_prev <= '0;
    end else begin
      vma <= vma_next;
      if (prev_load) vma_prev <= vma;
    end
  end

  // A start is accepted from IDLE, or in REQ only when the ack retires the
  // outstanding request in the same cycle; otherwise it is refused, not queued.
  always_comb begin
    state_next = state;
    addr_load  = 1'b0;
    case (state)
      IDLE: begin
        if (mem_start) begin
          state_next = REQ;
          addr_load  = 1'b1;
        end
      end
      REQ: begin
        if (mem_ack && mem_start) begin
          addr_load = 1'b1;
        end else if (mem_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      mem_addr <= '0;
    end else begin
      state <= state_next;
      if (addr_load) mem_addr <= vma;
    end
  end

  assign mem_busy = (state == REQ);
  assign mem_req  = (state == REQ);
  assign vma_wait = mem_start && mem_busy && !mem_ack;
  assign vmadrive = srcvma && (state_alu || state_write || state_fetch);

endmodule
